proj_hasher: RTL and testbench
==============================

# proj_hasher

Streaming MinHash front end that sits directly upstream of the sorter. It accepts one data element per cycle under a valid/ready handshake and computes a multiply-shift hash signature in a 3-stage pipeline. Each signature is tagged with the element's running index, and the block drives the sorter's signature/index inputs every cycle. It also brackets each frame: it clears the sorter at frame start and signals when the sorter has absorbed the last element.

## Interface
- SIGNATURE_LEN, proj_pkg::HASHER_SORTER_SIGNATURE (32): signature width; also the data width.
- INDICE_LEN, proj_pkg::INDICE_LEN (16): index width.
- PIPE_DEPTH, proj_pkg::HASHER_PIPE_DEPTH (3): fixed at 3. The parameter exists for documentation only.

Ports:
- in_clk  in  1  clock; sole clock domain.
- in_rst_n  in  1  synchronous, active-low reset.
- in_cfg_we  in  1  loads in_cfg_a/in_cfg_b; honoured only in IDLE.
- in_cfg_a  in  SIGNATURE_LEN  hash multiplier A.
- in_cfg_b  in  2*SIGNATURE_LEN  hash addend B.
- in_start  in  1  begins a frame; honoured only in IDLE.
- in_valid  in  1  in_data is valid.
- in_data  in  SIGNATURE_LEN  element to hash.
- in_last  in  1  qualifies the final element of a frame.
- out_ready  out  1  element accepted when in_valid && out_ready.
- out_signature  out  SIGNATURE_LEN  to sorter in_signature.
- out_index  out  INDICE_LEN  to sorter in_index.
- out_clear_n  out  1  to sorter in_rst_n; low for exactly one cycle per frame start.
- out_busy  out  1  high when state != IDLE.
- out_done  out  1  one-cycle pulse; sorter outputs are final.
- out_overflow  out  1  sticky; set when more than 2^INDICE_LEN elements arrive in a frame.

## Operation
- Hash: p = (A*data + B) mod 2^(2*SIGNATURE_LEN). sig = p[2*SIGNATURE_LEN-1 -: SIGNATURE_LEN].
- Clamp: if sig is all ones, output all ones minus 1. All ones is reserved as the "empty" signature.
- Empty pipeline slot: out_signature = '1 and out_index = '0. This matches the sorter reset value, so empty slots never displace stored entries.
- Index counter:
  - Cleared to 0 in CLEAR.
  - Increments on each accepted element; the first element of a frame gets index 0.
  - At 2^INDICE_LEN-1 it holds. Further accepted elements reuse index max and set out_overflow.
  - out_overflow clears only in CLEAR or on reset.
- FSM states:
  - IDLE: out_ready=0. On in_start go to CLEAR. A simultaneous in_cfg_we is applied in the same cycle.
  - CLEAR: lasts 1 cycle. out_clear_n=0, counter cleared, overflow cleared. Next state RUN.
  - RUN: out_ready=1. Accepting an element with in_last=1 goes to DRAIN, and out_ready drops in the next cycle.
  - DRAIN: out_ready=0. Waits until the last element's signature has been presented, then goes to DONE.
  - DONE: lasts 1 cycle. out_done=1. Next state IDLE.
- Ignored inputs:
  - in_start outside IDLE.
  - in_cfg_we outside IDLE.
  - in_valid while out_ready=0.
- in_last is meaningful only on an accepted beat.
- Reset, including mid-frame:
  - All valid bits cleared; state goes to IDLE.
  - Outputs take their reset values; A and B are reset to 0.
  - out_clear_n is not asserted by reset, because the sorter shares in_rst_n.

## Timing
Reset values of all outputs:
- out_ready=0, out_signature='1, out_index=0.
- out_clear_n=1, out_busy=0, out_done=0, out_overflow=0.

Cycle-level behaviour:
- in_start sampled in cycle t: out_clear_n=0 in t+1, out_ready=1 from t+2.
- Latency: an element accepted at edge t appears on out_signature/out_index, registered, during cycle t+3. The sorter captures it at edge t+4.
- Throughput: one element per cycle; no backpressure from the sorter.
- Last element accepted at t:
  - DRAIN covers cycles t+1 to t+3.
  - out_done is high during cycle t+4, after the sorter has registered the element.
  - out_busy falls at t+5.
- A frame of one element with in_last set is legal.
- Bubbles (in_valid=0 in RUN) produce empty slots and do not advance the index.

## Structure
- proj_pkg adds:
  - HASHER_PIPE_DEPTH=3.
  - The hasher_state_e enum {IDLE, CLEAR, RUN, DRAIN, DONE}.
  - The EMPTY_SIGNATURE constant ('1).
  - The hash_slot struct {valid, signature, index}.
- One sub-module, proj_hash_pipe, contains the 3-stage arithmetic pipeline:
  - Stage 1: register data, index and valid.
  - Stage 2: multiply.
  - Stage 3: add B, slice, clamp, and substitute the empty value.
- proj_hash_pipe also exposes its last-stage valid bit to the FSM for the DRAIN exit condition.
- The top level holds the FSM, index counter, overflow flag and config registers.

## Test plan
- Basic hash: A=0x0001_0000, B=0, start, then data 0x0003_0000 (last).
  - out_signature=0x0000_0003 and index 0, 3 cycles after acceptance.
  - out_done 4 cycles after acceptance.
- Clamp: A=0xFFFF_FFFF, B=0xFFFF_FFFF, data 0xFFFF_FFFF.
  - Raw upper half is 0xFFFF_FFFF, so the output is 0xFFFF_FFFE.
- Bubbles: 4 elements with in_valid toggling 1,0,1,0,1,0,1.
  - Indices 0,1,2,3 in order.
  - Each empty slot shows signature 0xFFFF_FFFF and index 0.
- Frame clear and end to end with the sorter: after a 5-element frame, start a new frame.
  - out_clear_n is low for exactly one cycle.
  - Sorter outputs reflect only the new frame.
- Overflow: INDICE_LEN=4, 18 elements.
  - Indices saturate at 15.
  - out_overflow rises on the 17th element and clears on the next start.
- Illegal/asynchronous events:
  - in_start and in_cfg_we during RUN are ignored; hash values are unchanged.
  - in_rst_n low mid-DRAIN: next cycle IDLE, out_done never pulses, outputs at reset values.

Source files
------------

// File: rtl/proj_pkg.sv
// proj_pkg: shared constants and types for the MinHash hasher front end.
package proj_pkg;
    localparam int HASHER_SORTER_SIGNATURE = 32;
    localparam int INDICE_LEN = 16;
    localparam int HASHER_PIPE_DEPTH = 3;
    // All ones marks an empty slot; it matches the sorter reset value.
    localparam logic [HASHER_SORTER_SIGNATURE-1:0] EMPTY_SIGNATURE = '1;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} hasher_state_e;
    typedef struct packed {
        logic valid;
        logic [HASHER_SORTER_SIGNATURE-1:0] signature;
        logic [INDICE_LEN-1:0] index;
    } hash_slot_t;
endpackage

// File: rtl/proj_hash_pipe.sv
// proj_hash_pipe: 3-stage multiply-shift hash pipeline with empty-slot substitution.
module proj_hash_pipe #(
    parameter int SIGNATURE_LEN = 32,
    parameter int INDICE_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic last,
    input  logic [SIGNATURE_LEN-1:0] data,
    input  logic [INDICE_LEN-1:0] index,
    input  logic [SIGNATURE_LEN-1:0] cfg_a,
    input  logic [2*SIGNATURE_LEN-1:0] cfg_b,
    output logic [SIGNATURE_LEN-1:0] signature,
    output logic [INDICE_LEN-1:0] sig_index,
    output logic last_valid
);
    localparam int PW = 2 * SIGNATURE_LEN;
    localparam logic [SIGNATURE_LEN-1:0] CLAMPED = {{(SIGNATURE_LEN-1){1'b1}}, 1'b0};
    logic v1, v2, l1, l2;
    logic [SIGNATURE_LEN-1:0] d1, hi, clamped;
    logic [INDICE_LEN-1:0] i1, i2;
    logic [PW-1:0] prod2, sum;
    always_comb begin
        sum = prod2 + cfg_b;
        hi = sum[PW-1 -: SIGNATURE_LEN];
        clamped = &hi ? CLAMPED : hi;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            l1 <= 1'b0;
            l2 <= 1'b0;
            last_valid <= 1'b0;
            signature <= '1;
            sig_index <= '0;
        end else begin
            v1 <= valid;
            v2 <= v1;
            l1 <= valid & last;
            l2 <= l1;
            last_valid <= l2;
            signature <= v2 ? clamped : '1;
            sig_index <= v2 ? i2 : '0;
        end
    end
    always_ff @(posedge clk) begin
        d1 <= data;
        i1 <= index;
        i2 <= i1;
        prod2 <= {{SIGNATURE_LEN{1'b0}}, d1} * {{SIGNATURE_LEN{1'b0}}, cfg_a};
    end
endmodule

// File: rtl/proj_hasher.sv
// proj_hasher: MinHash front end; frame FSM, index counter and hash config around the hash pipeline.
module proj_hasher
    import proj_pkg::*;
#(
    parameter int SIGNATURE_LEN = HASHER_SORTER_SIGNATURE,
    parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
    parameter int PIPE_DEPTH = HASHER_PIPE_DEPTH
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_cfg_we,
    input  logic [SIGNATURE_LEN-1:0] in_cfg_a,
    input  logic [2*SIGNATURE_LEN-1:0] in_cfg_b,
    input  logic in_start,
    input  logic in_valid,
    input  logic [SIGNATURE_LEN-1:0] in_data,
    input  logic in_last,
    output logic out_ready,
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0] out_index,
    output logic out_clear_n,
    output logic out_busy,
    output logic out_done,
    output logic out_overflow
);
    localparam logic [INDICE_LEN-1:0] ONE = 1;
    if (PIPE_DEPTH != 3) begin : g_depth_check
        $error("proj_hasher: PIPE_DEPTH must be 3");
    end
    hasher_state_e state;
    logic [SIGNATURE_LEN-1:0] cfg_a;
    logic [2*SIGNATURE_LEN-1:0] cfg_b;
    logic [INDICE_LEN-1:0] cnt;
    logic sat, accept, last_valid;
    assign accept = in_valid && out_ready;
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state <= IDLE;
            cfg_a <= '0;
            cfg_b <= '0;
            cnt <= '0;
            sat <= 1'b0;
            out_ready <= 1'b0;
            out_clear_n <= 1'b1;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            out_clear_n <= 1'b1;
            out_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_cfg_we) begin
                        cfg_a <= in_cfg_a;
                        cfg_b <= in_cfg_b;
                    end
                    if (in_start) begin
                        state <= CLEAR;
                        out_clear_n <= 1'b0;
                        out_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= RUN;
                    cnt <= '0;
                    sat <= 1'b0;
                    out_overflow <= 1'b0;
                    out_ready <= 1'b1;
                end
                RUN: if (accept) begin
                    // The counter sticks at max; the second hit at max is the overflowing element.
                    if (cnt != '1) cnt <= cnt + ONE;
                    else if (sat) out_overflow <= 1'b1;
                    else sat <= 1'b1;
                    if (in_last) begin
                        state <= DRAIN;
                        out_ready <= 1'b0;
                    end
                end
                DRAIN: if (last_valid) begin
                    state <= DONE;
                    out_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    out_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    proj_hash_pipe #(.SIGNATURE_LEN(SIGNATURE_LEN), .INDICE_LEN(INDICE_LEN)) u_pipe (
        .clk(in_clk),
        .rst_n(in_rst_n),
        .valid(accept),
        .last(in_last),
        .data(in_data),
        .index(cnt),
        .cfg_a(cfg_a),
        .cfg_b(cfg_b),
        .signature(out_signature),
        .sig_index(out_index),
        .last_valid(last_valid)
    );
endmodule

// File: tb/tb_proj_hasher.sv
// tb_proj_hasher: cycle-scheduled behavioural model of proj_hasher with randomized frames.
module tb_proj_hasher;
    localparam int IL = 4;
    localparam int N = 2048;
    logic in_clk = 0, in_rst_n = 0, in_cfg_we = 0, in_start = 0, in_valid = 0, in_last = 0;
    logic [31:0] in_cfg_a = 0, in_data = 0;
    logic [63:0] in_cfg_b = 0;
    logic out_ready, out_clear_n, out_busy, out_done, out_overflow;
    logic [31:0] out_signature;
    logic [IL-1:0] out_index;

    proj_hasher #(.INDICE_LEN(IL)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_cfg_we(in_cfg_we), .in_cfg_a(in_cfg_a),
        .in_cfg_b(in_cfg_b), .in_start(in_start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_ready(out_ready), .out_signature(out_signature),
        .out_index(out_index), .out_clear_n(out_clear_n), .out_busy(out_busy),
        .out_done(out_done), .out_overflow(out_overflow)
    );

    always #5 in_clk = ~in_clk;
    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    // Expected outputs per cycle, filled in ahead of time by the stimulus tasks.
    logic [31:0] e_sig[N];
    logic [IL-1:0] e_idx[N];
    bit e_ready[N], e_clear[N], e_busy[N], e_done[N], e_ovf[N];
    logic [31:0] h_sig[N];
    logic [IL-1:0] h_idx[N];
    logic h_ready[N], h_clear[N], h_busy[N], h_done[N], h_ovf[N];
    int checks = 0, failures = 0;
    logic [31:0] m_a = 0;
    logic [63:0] m_b = 0;
    logic [31:0] dq[$];

    function automatic logic [31:0] hash(logic [31:0] a, logic [63:0] b, logic [31:0] d);
        logic [63:0] p;
        p = 64'(a) * 64'(d) + b;
        return (p[63:32] == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : p[63:32];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_future(int from);
        for (int k = from; k < N; k++) begin
            e_sig[k] = '1; e_idx[k] = '0; e_ready[k] = 0; e_clear[k] = 1;
            e_busy[k] = 0; e_done[k] = 0; e_ovf[k] = 0;
        end
    endtask

    task automatic fill_ovf(int from, bit v);
        for (int k = from; k < N; k++) e_ovf[k] = v;
    endtask

    always @(negedge in_clk) if (cyc >= 1 && cyc < N) begin
        h_sig[cyc] = out_signature; h_idx[cyc] = out_index; h_ready[cyc] = out_ready;
        h_clear[cyc] = out_clear_n; h_busy[cyc] = out_busy; h_done[cyc] = out_done;
        h_ovf[cyc] = out_overflow;
        check("signature", 64'(out_signature), 64'(e_sig[cyc]));
        check("index", 64'(out_index), 64'(e_idx[cyc]));
        check("ready", 64'(out_ready), 64'(e_ready[cyc]));
        check("clear_n", 64'(out_clear_n), 64'(e_clear[cyc]));
        check("busy", 64'(out_busy), 64'(e_busy[cyc]));
        check("done", 64'(out_done), 64'(e_done[cyc]));
        check("overflow", 64'(out_overflow), 64'(e_ovf[cyc]));
    end

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_start = 0; in_cfg_we = 0; in_valid = 0; in_last = 0;
    endtask

    // Random traffic that the DUT must ignore; start/cfg only when full is set.
    task automatic drive_junk(bit full);
        in_valid = 1'($urandom_range(1)); in_last = 1'($urandom_range(1)); in_data = $urandom;
        in_start = full ? 1'($urandom_range(1)) : 1'b0;
        in_cfg_we = full ? 1'($urandom_range(1)) : 1'b0;
        in_cfg_a = $urandom; in_cfg_b = {$urandom, $urandom};
    endtask

    task automatic cfg(logic [31:0] a, logic [63:0] b);
        step(); idle_inputs();
        in_cfg_we = 1; in_cfg_a = a; in_cfg_b = b; m_a = a; m_b = b;
        step(); idle_inputs();
    endtask

    // mode 0: valid every cycle, 1: alternating, 2: random bubbles.
    task automatic frame(input int n, input int mode, input bit junk, input bit do_cfg,
                         input logic [31:0] ca, input logic [63:0] cb, input bit rst_drain,
                         output int s, output int t);
        int k = 0, p = 0, c = 0;
        bit v;
        step(); idle_inputs();
        s = cyc;
        in_start = 1;
        if (do_cfg) begin
            in_cfg_we = 1; in_cfg_a = ca; in_cfg_b = cb; m_a = ca; m_b = cb;
        end
        e_clear[s+1] = 0; e_busy[s+1] = 1; fill_ovf(s + 2, 0);
        step(); drive_junk(junk);
        while (k < n) begin
            step();
            c = cyc;
            e_ready[c] = 1; e_busy[c] = 1;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (p % 2 == 0) : ($urandom_range(99) >= 30);
            p++;
            drive_junk(junk);
            in_valid = v;
            if (v) begin
                if (dq.size() > 0) in_data = dq.pop_front();
                in_last = (k == n - 1);
                e_sig[c+3] = hash(m_a, m_b, in_data);
                e_idx[c+3] = (k < 15) ? IL'(k) : IL'(15);
                if (k >= 16) fill_ovf(c + 1, 1);
                k++;
            end
        end
        t = c;
        e_done[t+4] = 1;
        for (int i = 1; i <= 4; i++) e_busy[t+i] = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            drive_junk(junk && !rst_drain);
            in_rst_n = !(rst_drain && i == 2);
            if (rst_drain && i == 2) begin
                clear_future(cyc + 1);
                m_a = 0; m_b = 0;
            end
        end
        step(); idle_inputs(); in_rst_n = 1;
    endtask

    initial begin
        int s, t;
        clear_future(0);
        repeat (3) step();
        in_rst_n = 1;
        step();
        // Basic hash.
        cfg(32'h0001_0000, 64'h0);
        dq = {32'h0003_0000};
        frame(1, 0, 0, 0, 0, 0, 0, s, t);
        check("basic_sig", 64'(h_sig[t+3]), 64'h3);
        check("basic_idx", 64'(h_idx[t+3]), 64'h0);
        check("basic_done", 64'(h_done[t+4]), 64'h1);
        check("basic_clear", 64'(h_clear[s+1]), 64'h0);
        check("basic_busy_fall", 64'(h_busy[t+5]), 64'h0);
        // Clamp, config loaded together with start.
        dq = {32'hFFFF_FFFF};
        frame(1, 0, 0, 1, 32'hFFFF_FFFF, 64'hFFFF_FFFF, 0, s, t);
        check("clamp_sig", 64'(h_sig[t+3]), 64'hFFFF_FFFE);
        // Bubbles.
        cfg($urandom, {$urandom, $urandom});
        frame(4, 1, 0, 0, 0, 0, 0, s, t);
        for (int i = 0; i < 4; i++) check("bubble_idx", 64'(h_idx[s+5+2*i]), 64'(i));
        check("bubble_empty_sig", 64'(h_sig[s+6]), 64'hFFFF_FFFF);
        check("bubble_empty_idx", 64'(h_idx[s+6]), 64'h0);
        // Random frames with ignored start/cfg/valid traffic.
        repeat (8) begin
            frame($urandom_range(12, 1), 2, 1, 1'($urandom_range(1)), $urandom,
                  {$urandom, $urandom}, 0, s, t);
        end
        // Index saturation and overflow.
        frame(18, 0, 1, 0, 0, 0, 0, s, t);
        check("ovf_idx17", 64'(h_idx[s+21]), 64'd15);
        check("ovf_idx18", 64'(h_idx[s+22]), 64'd15);
        check("ovf_low_after16", 64'(h_ovf[s+18]), 64'h0);
        check("ovf_high_after17", 64'(h_ovf[s+19]), 64'h1);
        frame(2, 0, 0, 0, 0, 0, 0, s, t);
        check("ovf_held_in_clear", 64'(h_ovf[s+1]), 64'h1);
        check("ovf_cleared", 64'(h_ovf[s+2]), 64'h0);
        // Reset while draining.
        frame(3, 0, 1, 0, 0, 0, 1, s, t);
        check("rst_no_done", 64'(h_done[t+4]), 64'h0);
        check("rst_busy", 64'(h_busy[t+3]), 64'h0);
        check("rst_sig", 64'(h_sig[t+3]), 64'hFFFF_FFFF);
        // Recovery after reset, config back to zero first.
        frame(5, 2, 0, 0, 0, 0, 0, s, t);
        frame(5, 2, 1, 1, $urandom, {$urandom, $urandom}, 0, s, t);
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
